// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message feeder.
package sha256_pkg;

  localparam int SHA256_BLOCK_W  = 512;
  localparam int SHA256_DIGEST_W = 256;
  localparam int SHA256_LEN_W    = 64;

  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } sha256_feeder_state_t;

  // Message bit length after an optional byte; wraps modulo 2^64.
  function automatic logic [SHA256_LEN_W-1:0] sha256_len_add(
    input logic [SHA256_LEN_W-1:0] len,
    input logic                    has_byte
  );
    return len + {60'd0, has_byte, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_pad_insert.sv
// Combinational padding: final block (0x80, zeros, optional length) and
// the overflow block used when the length no longer fits.
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [SHA256_BLOCK_W-1:0] block,
  input  logic [6:0]                n,
  input  logic [SHA256_LEN_W-1:0]   bit_len,
  output logic [SHA256_BLOCK_W-1:0] final_block,
  output logic [SHA256_BLOCK_W-1:0] extra_block
);

  logic [SHA256_BLOCK_W-1:0] body;

  // Keep bytes below n, put the pad marker at n, zero everything above
  always_comb begin
    body = '0;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) < n) begin
        body[511-8*i -: 8] = block[511-8*i -: 8];
      end else if (7'(i) == n) begin
        body[511-8*i -: 8] = SHA256_PAD_BYTE;
      end else begin
        body[511-8*i -: 8] = 8'h00;
      end
    end
  end

  assign final_block = (n <= 7'd55) ? {body[511:64], bit_len} : body;
  assign extra_block = {((n == 7'd64) ? SHA256_PAD_BYTE : 8'h00), 440'd0, bit_len};

endmodule

// File: rtl/sha256_msg_feeder.sv
// Byte-stream front end for a SHA-256 core: packs bytes into 512-bit blocks,
// pads the tail, sequences init/next pulses and returns the final digest.
module sha256_msg_feeder
  import sha256_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 msg_data,
  input  logic                       msg_valid,
  input  logic                       msg_last,
  input  logic                       msg_empty,
  output logic                       msg_ready,
  output logic                       core_init,
  output logic                       core_next,
  output logic [SHA256_BLOCK_W-1:0]  core_block,
  input  logic                       core_ready,
  input  logic [SHA256_DIGEST_W-1:0] core_digest,
  input  logic                       core_digest_valid,
  output logic [SHA256_DIGEST_W-1:0] digest,
  output logic                       digest_valid
);

  sha256_feeder_state_t state;
  logic [6:0]                p;
  logic [SHA256_LEN_W-1:0]   bit_len;
  logic                      first;
  logic                      final_blk;
  logic                      extra;

  logic                      accept;
  logic                      has_byte;
  logic [6:0]                n;
  logic [SHA256_LEN_W-1:0]   len_next;
  logic [SHA256_BLOCK_W-1:0] blk_ins;
  logic [SHA256_BLOCK_W-1:0] padded_block;
  logic [SHA256_BLOCK_W-1:0] extra_block;

  assign accept   = (state == S_FILL) && msg_valid && msg_ready;
  assign has_byte = accept && !(msg_last && msg_empty);
  assign n        = p + {6'd0, has_byte};
  assign len_next = sha256_len_add(bit_len, has_byte);

  // Current block with the incoming byte dropped in at position p
  always_comb begin
    blk_ins = core_block;
    for (int i = 0; i < 64; i++) begin
      if (p == 7'(i)) begin
        blk_ins[511-8*i -: 8] = msg_data;
      end else begin
        blk_ins[511-8*i -: 8] = core_block[511-8*i -: 8];
      end
    end
  end

  sha256_pad_insert u_pad (
    .block       (blk_ins),
    .n           (n),
    .bit_len     (len_next),
    .final_block (padded_block),
    .extra_block (extra_block)
  );

  // Sequencer: fill, pad, hand blocks to the core, collect digests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FILL;
      msg_ready    <= 1'b0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_block   <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      bit_len      <= '0;
      p            <= 7'd0;
      first        <= 1'b1;
      final_blk    <= 1'b0;
      extra        <= 1'b0;
    end else begin
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept && msg_last) begin
            core_block <= padded_block;
            bit_len    <= len_next;
            p          <= n;
            final_blk  <= (n <= 7'd55);
            extra      <= (n > 7'd55);
            msg_ready  <= 1'b0;
            state      <= S_SEND;
          end else if (accept) begin
            core_block <= blk_ins;
            bit_len    <= len_next;
            if (p == 7'd63) begin
              p         <= 7'd0;
              final_blk <= 1'b0;
              msg_ready <= 1'b0;
              state     <= S_SEND;
            end else begin
              p         <= p + 7'd1;
              msg_ready <= 1'b1;
            end
          end else begin
            msg_ready <= 1'b1;
          end
        end
        S_SEND: begin
          msg_ready <= 1'b0;
          if (core_ready) begin
            core_init <= first;
            core_next <= !first;
            first     <= 1'b0;
            state     <= S_WAIT;
          end else begin
            state <= S_SEND;
          end
        end
        S_WAIT: begin
          // The core drops digest_valid right after a pulse, so no stale sample here
          if (core_digest_valid && final_blk) begin
            digest       <= core_digest;
            digest_valid <= 1'b1;
            first        <= 1'b1;
            bit_len      <= '0;
            p            <= 7'd0;
            extra        <= 1'b0;
            msg_ready    <= 1'b1;
            state        <= S_FILL;
          end else if (core_digest_valid && extra) begin
            core_block <= extra_block;
            final_blk  <= 1'b1;
            extra      <= 1'b0;
            msg_ready  <= 1'b0;
            state      <= S_SEND;
          end else if (core_digest_valid) begin
            core_block <= '0;
            p          <= 7'd0;
            msg_ready  <= 1'b1;
            state      <= S_FILL;
          end else begin
            msg_ready <= 1'b0;
          end
        end
        default: begin
          msg_ready <= 1'b0;
          state     <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core attached, known
// vectors plus randomized messages checked against a byte-level SHA-256 model.
module tb_sha256_msg_feeder;

  typedef logic [7:0] bytes_t[$];

  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_64A   = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   msg_data;
  logic         msg_valid, msg_last, msg_empty, msg_ready;
  logic         core_init, core_next, core_ready, core_digest_valid;
  logic [511:0] core_block;
  logic [255:0] core_digest, digest;
  logic         digest_valid;

  always #5 clk = ~clk;

  sha256_msg_feeder dut (
    .clk(clk), .reset(reset),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_empty(msg_empty), .msg_ready(msg_ready),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest),
    .core_digest_valid(core_digest_valid),
    .digest(digest), .digest_valid(digest_valid)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, bb, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Reference: standard SHA-256 over the whole byte string
  function automatic logic [255:0] ref_sha(input bytes_t m);
    bytes_t       pb;
    logic [255:0] h;
    logic [511:0] blk;
    logic [63:0]  bl;
    pb = m;
    bl = 64'(m.size()) * 64'd8;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pb.push_back(bl[8*i +: 8]);
    h = H0;
    for (int bi = 0; bi < pb.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[64*bi+j];
      h = compress(h, blk);
    end
    return h;
  endfunction

  // Behavioural core: busy 65 cycles after a pulse, digest_valid on the 66th
  logic         model_ready, hold;
  int           busy;
  logic [255:0] h_r, pend;
  assign core_ready  = model_ready & ~hold;
  assign core_digest = h_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_ready <= 1'b1; busy <= 0; core_digest_valid <= 1'b0; h_r <= '0; pend <= '0;
    end else begin
      core_digest_valid <= 1'b0;
      if (core_init || core_next) begin
        pend <= compress(core_init ? H0 : h_r, core_block);
        busy <= 65;
        model_ready <= 1'b0;
      end else if (busy > 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          core_digest_valid <= 1'b1;
          model_ready <= 1'b1;
          h_r <= pend;
        end
      end
    end
  end

  // Monitors record pulses, blocks and digests for the main thread to check
  int           cyc = 0;
  int           last_pulse_cyc = 0;
  int           viol = 0;
  logic         ready_prev = 1'b1;
  int           pulse_kind_q[$];
  int           pulse_cyc_q[$];
  logic [511:0] block_q[$];
  logic [255:0] dv_digest_q[$];
  int           dv_gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (core_init || core_next) begin
        if (!ready_prev) viol <= viol + 1;
        pulse_kind_q.push_back(core_init ? 1 : 2);
        pulse_cyc_q.push_back(cyc);
        block_q.push_back(core_block);
        last_pulse_cyc <= cyc;
      end
      if (digest_valid) begin
        dv_digest_q.push_back(digest);
        dv_gap_q.push_back(cyc - last_pulse_cyc);
      end
    end
    ready_prev <= core_ready;
  end

  int           n_checks = 0;
  int           n_errors = 0;
  logic [255:0] exp_q[$];
  int           checked = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic put_beat(input logic [7:0] d, input logic last, input logic empty);
    int t;
    @(negedge clk);
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_empty = empty;
    t = 0;
    while (!msg_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check_eq("beat_timeout", 512'(t), 512'd0);
    @(posedge clk);
  endtask

  task automatic send_msg(input bytes_t m, input int gap);
    if (m.size() == 0) begin
      put_beat(8'h00, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < m.size(); i++) begin
        int g;
        logic is_last;
        g = (gap > 0) ? $urandom_range(0, gap) : 0;
        repeat (g) begin
          @(negedge clk);
          msg_valid = 1'b0;
          msg_data  = 8'($urandom);
        end
        is_last = (i == m.size() - 1);
        put_beat(m[i], is_last, is_last ? 1'b0 : ((gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0));
      end
    end
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0; msg_empty = 1'b0;
  endtask

  task automatic run_msg(input bytes_t m, input int gap, input logic [255:0] expv);
    exp_q.push_back(expv);
    send_msg(m, gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (dv_digest_q.size() < exp_q.size() && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq("digest_count", 512'(dv_digest_q.size()), 512'(exp_q.size()));
    while (checked < dv_digest_q.size() && checked < exp_q.size()) begin
      check_eq("digest", 512'(dv_digest_q[checked]), 512'(exp_q[checked]));
      check_eq("latency", 512'(dv_gap_q[checked]), 512'd67);
      checked++;
    end
  endtask

  task automatic check_pulses(input string tag, input int base, input int count, input int kind0);
    check_eq({tag, "_pulses"}, 512'(pulse_kind_q.size() - base), 512'(count));
    if (pulse_kind_q.size() > base) check_eq({tag, "_first_kind"}, 512'(pulse_kind_q[base]), 512'(kind0));
    else check_eq({tag, "_first_kind"}, 512'd0, 512'(kind0));
  endtask

  initial begin
    bytes_t       m;
    string        s;
    int           bp, bb, rel_cyc;
    logic [511:0] blk;
    int           lens [12] = '{0, 1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 128};

    reset = 1'b1; hold = 1'b0;
    msg_valid = 1'b0; msg_data = 8'h00; msg_last = 1'b0; msg_empty = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_msg_ready", 512'(msg_ready), 512'd0);
    check_eq("rst_pulses", 512'({core_init, core_next, digest_valid}), 512'd0);
    check_eq("rst_digest", 512'(digest), 512'd0);
    check_eq("rst_block", core_block, 512'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_clock", 512'(msg_ready), 512'd1);

    // "abc"
    bp = pulse_kind_q.size(); bb = block_q.size();
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, D_ABC); drain();
    check_pulses("abc", bp, 1, 1);
    blk = (block_q.size() > bb) ? block_q[bb] : '0;
    check_eq("abc_len", 512'(blk[63:0]), 512'h18);
    check_eq("abc_head", 512'(blk[511:480]), 512'h61626380);
    check_eq("digest_held", 512'(digest), 512'(D_ABC));

    // empty message
    bp = pulse_kind_q.size(); bb = block_q.size();
    m.delete();
    run_msg(m, 0, D_EMPTY); drain();
    check_pulses("empty", bp, 1, 1);
    blk = (block_q.size() > bb) ? block_q[bb] : '0;
    check_eq("empty_block", blk, {8'h80, 504'd0});

    // 56-byte message: length spills into a second block
    bp = pulse_kind_q.size(); bb = block_q.size();
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    run_msg(m, 0, D_56); drain();
    check_pulses("m56", bp, 2, 1);
    if (pulse_kind_q.size() > bp + 1) check_eq("m56_second_kind", 512'(pulse_kind_q[bp+1]), 512'd2);
    else check_eq("m56_second_kind", 512'd0, 512'd2);
    blk = (block_q.size() > bb + 1) ? block_q[bb+1] : '0;
    check_eq("m56_extra", blk, 512'h1c0);

    // 64 x 'a': extra block starts with the pad marker
    bp = pulse_kind_q.size(); bb = block_q.size();
    m.delete();
    repeat (64) m.push_back(8'h61);
    run_msg(m, 0, D_64A); drain();
    check_pulses("m64", bp, 2, 1);
    blk = (block_q.size() > bb + 1) ? block_q[bb+1] : '0;
    check_eq("m64_extra", blk, {8'h80, 440'd0, 64'h200});

    // core_ready held low while the feeder waits to send
    bp = pulse_kind_q.size();
    hold = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, D_ABC);
    repeat (5) @(negedge clk);
    rel_cyc = cyc;
    hold = 1'b0;
    drain();
    check_pulses("hold", bp, 1, 1);
    if (pulse_cyc_q.size() > bp) check_eq("hold_no_early_pulse", 512'(pulse_cyc_q[bp] > rel_cyc), 512'd1);
    else check_eq("hold_no_early_pulse", 512'd0, 512'd1);

    // randomized back-to-back messages with gaps and stray msg_empty
    for (int k = 0; k < 15; k++) begin
      int len;
      len = (k < 12) ? lens[k] : $urandom_range(0, 140);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, 3, ref_sha(m));
    end
    drain();

    // reset in the middle of a block aborts it
    for (int i = 0; i < 20; i++) put_beat(8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    msg_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_block", core_block, 512'd0);
    reset = 1'b0;
    bp = pulse_kind_q.size();
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, D_ABC); drain();
    check_pulses("midrst", bp, 1, 1);

    check_eq("pulse_while_busy", 512'(viol), 512'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
